// File: rtl/mem_pkg.sv
// Shared memory-command constants and arbiter state encoding used by the
// CPU FSM, the loader path and the memory arbiter.
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the requester not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       winner,
  output logic       valid
);

  // Select the winning requester index from the request vector.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a synchronous-read single-port RAM.
// Each access takes ACCESS then DONE; the winner's ack pulses in DONE.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    grant,
  output logic          busy
);

  arb_state_t    state_r;
  logic          win_r;
  logic          last_served_r;
  logic          rd_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          ram_write_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_din_r;
  logic [1:0]    grant_r;
  logic          busy_r;

  logic          last_s;
  logic          pick_s;
  logic          valid_s;
  logic [1:0]    sel_cmd_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // In DONE the current winner counts as last served so the other side goes next.
  always_comb begin
    if (state_r == DONE) begin
      last_s = win_r;
    end else begin
      last_s = last_served_r;
    end
  end

  rr_pick2 u_pick (
    .req         ({req1, req0}),
    .last_served (last_s),
    .winner      (pick_s),
    .valid       (valid_s)
  );

  // Route the picked requester's command, address and data.
  always_comb begin
    if (pick_s) begin
      sel_cmd_s   = cmd1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_cmd_s   = cmd0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Arbiter FSM; every output is a register so req never reaches ack or ram_write combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      win_r         <= 1'b0;
      last_served_r <= 1'b1;
      rd_r          <= 1'b0;
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      ram_write_r   <= 1'b0;
      ram_addr_r    <= {AW{1'b0}};
      ram_din_r     <= {DW{1'b0}};
      grant_r       <= 2'b00;
      busy_r        <= 1'b0;
    end else begin
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      ram_write_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (state_r == DONE) begin
            last_served_r <= win_r;
          end
          if (valid_s) begin
            state_r     <= ACCESS;
            win_r       <= pick_s;
            rd_r        <= (sel_cmd_s == MREAD);
            ram_write_r <= (sel_cmd_s == MWRITE);
            ram_addr_r  <= sel_addr_s;
            ram_din_r   <= sel_wdata_s;
            grant_r     <= onehot2(pick_s);
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
          end
        end
        ACCESS: begin
          state_r <= DONE;
          ack0_r  <= ~win_r;
          ack1_r  <= win_r;
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'b00;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // RAM read data lands during DONE, so it is gated straight through by the registered ack.
  always_comb begin
    if (ack0_r && rd_r) begin
      rdata0 = ram_dout;
    end else begin
      rdata0 = {DW{1'b0}};
    end
    if (ack1_r && rd_r) begin
      rdata1 = ram_dout;
    end else begin
      rdata1 = {DW{1'b0}};
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign ram_addr  = ram_addr_r;
  assign ram_write = ram_write_r;
  assign ram_din   = ram_din_r;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and per-requester
// scoreboards of expected read data.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [1:0]    cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [1:0]    grant;
  logic          busy;

  logic          mem_init;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pend0 = 0, pend1 = 0;
  int ack_cyc0 = 0, ack_cyc1 = 0;
  int wr_count = 0;
  int prev_port = -1;
  bit pulse0 = 1'b0;
  bit alt_chk = 1'b0;
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'(i) ^ 16'hC3C3;
  endfunction

  // Synchronous-read single-port RAM, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
    end else if (ram_write) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    if (ram_write) begin
      wr_count++;
      chk("wr_only_when_busy", 32'(busy), 32'd1);
    end
    if (ack0 && ack1) chk("dual_ack", 32'(ack0 & ack1), 32'd0);
    if (ack0) begin
      if (sb0.size() == 0) begin
        chk("ack0_unexpected", 32'(sb0.size()), 32'd1);
      end else begin
        e = sb0.pop_front();
        chk("rdata0", 32'(rdata0), 32'(e));
        chk("rdata1_quiet", 32'(rdata1), 32'd0);
      end
      ack_cyc0 = cyc;
      if (alt_chk && prev_port >= 0) chk("alternate_after0", 32'(prev_port), 32'd1);
      prev_port = 0;
      pend0--;
      if (pend0 <= 0 || pulse0) req0 = 1'b0;
    end else if (pulse0 && pend0 > 0 && !req0) begin
      req0 = 1'b1;
    end
    if (ack1) begin
      if (sb1.size() == 0) begin
        chk("ack1_unexpected", 32'(sb1.size()), 32'd1);
      end else begin
        e = sb1.pop_front();
        chk("rdata1", 32'(rdata1), 32'(e));
        chk("rdata0_quiet", 32'(rdata0), 32'd0);
      end
      ack_cyc1 = cyc;
      if (alt_chk && prev_port >= 0) chk("alternate_after1", 32'(prev_port), 32'd0);
      prev_port = 1;
      pend1--;
      if (pend1 <= 0) req1 = 1'b0;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((pend0 > 0 || pend1 > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk("run_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic issue0(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp, input int n);
    cmd0 = c; addr0 = a; wdata0 = d;
    for (int k = 0; k < n; k++) sb0.push_back(exp);
    pend0 += n;
    req0 = 1'b1;
  endtask

  task automatic issue1(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp, input int n);
    cmd1 = c; addr1 = a; wdata1 = d;
    for (int k = 0; k < n; k++) sb1.push_back(exp);
    pend1 += n;
    req1 = 1'b1;
  endtask

  initial begin
    int c0;
    int w;
    reset = 1'b1; mem_init = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cmd0 = MNONE; cmd1 = MNONE;
    addr0 = 9'h000; addr1 = 9'h000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    step(); step();
    chk("rst_grant_busy", 32'({grant, busy}), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    chk("rst_ram_ctl", 32'({ram_write, ram_addr}), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    mem_init = 1'b0; reset = 1'b0;
    step();

    // First tie after reset: requester 0, then requester 1 straight from DONE.
    issue0(MREAD, 9'h030, 16'h0000, init_val(9'h030), 1);
    issue1(MREAD, 9'h031, 16'h0000, init_val(9'h031), 1);
    c0 = cyc;
    step(); chk("tie_grant_first", 32'(grant), 32'h1);
    step(); step(); chk("tie_grant_second", 32'(grant), 32'h2);
    run(20);
    chk("tie_ack0_cycle", 32'(ack_cyc0 - c0), 32'd2);
    chk("tie_ack1_cycle", 32'(ack_cyc1 - c0), 32'd4);

    // Single write then read-back on requester 0.
    issue0(MWRITE, 9'h005, 16'hABCD, 16'h0000, 1);
    w = wr_count; c0 = cyc;
    step();
    chk("wr_access_ctl", 32'({grant, ram_write, ram_addr}), 32'({2'b01, 1'b1, 9'h005}));
    chk("wr_access_din", 32'(ram_din), 32'hABCD);
    run(20);
    chk("wr_pulse_count", 32'(wr_count - w), 32'd1);
    chk("wr_ack_latency", 32'(ack_cyc0 - c0), 32'd2);
    chk("addr_hold_idle", 32'({busy, ram_write, ram_addr}), 32'({1'b0, 1'b0, 9'h005}));
    issue0(MREAD, 9'h005, 16'h0000, 16'hABCD, 1);
    c0 = cyc;
    run(20);
    chk("rd_ack_latency", 32'(ack_cyc0 - c0), 32'd2);

    // No-op command still completes, never writes, returns zero.
    issue0(2'b11, 9'h007, 16'h1234, 16'h0000, 1);
    w = wr_count; c0 = cyc;
    run(20);
    chk("noop_no_write", 32'(wr_count - w), 32'd0);
    chk("noop_ack_latency", 32'(ack_cyc0 - c0), 32'd2);

    // Requester 1 held continuously, requester 0 pulsing: strict alternation.
    issue1(MWRITE, 9'h040, 16'h7777, 16'h0000, 3);
    issue0(MREAD, 9'h041, 16'h0000, init_val(9'h041), 3);
    pulse0 = 1'b1; alt_chk = 1'b1; prev_port = -1;
    run(60);
    pulse0 = 1'b0; alt_chk = 1'b0;
    issue1(MREAD, 9'h040, 16'h0000, 16'h7777, 1);
    run(20);

    // Reset in the middle of an ACCESS write must suppress the write and the ack.
    issue0(MWRITE, 9'h010, 16'h0BAD, 16'h0000, 1);
    run(20);
    cmd0 = MWRITE; addr0 = 9'h010; wdata0 = 16'hDEAD; req0 = 1'b1;
    step();
    chk("abort_in_access", 32'(ram_write), 32'd1);
    #1 reset = 1'b1;
    #1 chk("abort_write_drop", 32'(ram_write), 32'd0);
    chk("abort_busy_drop", 32'(busy), 32'd0);
    req0 = 1'b0;
    step();
    chk("abort_no_ack", 32'({ack1, ack0}), 32'd0);
    reset = 1'b0;
    step(); step();
    issue0(MREAD, 9'h010, 16'h0000, 16'h0BAD, 1);
    run(20);

    // Address extremes: no aliasing between 0x000 and 0x1FF.
    issue0(MWRITE, 9'h000, 16'h1111, 16'h0000, 1); run(20);
    issue0(MWRITE, 9'h1FF, 16'h5AA5, 16'h0000, 1); run(20);
    issue1(MREAD, 9'h000, 16'h0000, 16'h1111, 1); run(20);
    issue1(MREAD, 9'h1FF, 16'h0000, 16'h5AA5, 1); run(20);
    chk("addr_max_hold", 32'(ram_addr), 32'h1FF);

    chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
